// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: ALU control encodings and the HI/LO
// multiply/divide sequencer state type.
package mips_pkg;

  localparam logic [3:0] ALU_MULT = 4'b1000;
  localparam logic [3:0] ALU_DIV  = 4'b1001;
  localparam logic [3:0] ALU_MFHI = 4'b1010;
  localparam logic [3:0] ALU_MFLO = 4'b1011;

  localparam int unsigned MD_WIDTH     = 32;
  localparam logic [4:0]  MD_ITER_LAST = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit_if.sv
// EX-stage to HI/LO multiply/divide unit connection: issue fields going in,
// architectural HI/LO plus stall/completion status coming back.
interface muldiv_unit_if;

  logic        start;
  logic [3:0]  alucontrol;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        hien;
  logic        loen;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  modport master (
    output start, alucontrol, srca, srcb, hien, loen,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, alucontrol, srca, srcb, hien, loen,
    output hi, lo, busy, done
  );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative signed multiply / divide producing the MIPS HI and LO registers.
// Magnitudes are processed one bit per CALC cycle; signs are applied in FIX.
//
// state | meaning
// IDLE  | waiting for a MULT/DIV start, HI/LO stable
// CALC  | 32 shift-add or restoring-divide iterations
// FIX   | sign correction and enabled HI/LO write-back
module muldiv_unit
  import mips_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);

  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

  muldiv_state_t state_q;
  logic [4:0]    cnt_q;
  logic          is_div_q;
  logic          hien_q;
  logic          loen_q;
  logic          sign_a_q;
  logic          sign_b_q;
  logic          divz_q;
  logic [63:0]   mcand_q;
  logic [31:0]   mplier_q;
  logic [63:0]   acc_q;
  logic [32:0]   rem_q;
  logic [31:0]   quot_q;
  logic [31:0]   divisor_q;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;

  logic          valid_start;
  logic [63:0]   acc_d;
  logic [33:0]   rem_shift;
  logic [33:0]   rem_diff;
  logic          q_bit;
  logic [32:0]   rem_d;
  logic [31:0]   quot_d;
  logic [63:0]   prod_fix;
  logic [31:0]   quot_fix;
  logic [31:0]   rem_fix;
  logic [31:0]   res_hi;
  logic [31:0]   res_lo;

  assign valid_start = bus.start && ((bus.alucontrol == ALU_MULT) || (bus.alucontrol == ALU_DIV));

  assign acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // Partial remainder never reaches the divisor, so the top bit stays clear
  // and a 34-bit subtract exposes the borrow without losing a carry.
  assign rem_shift = {rem_q, quot_q[31]};
  assign rem_diff  = rem_shift - {2'b00, divisor_q};
  assign q_bit     = ~rem_diff[33];
  assign rem_d     = q_bit ? rem_diff[32:0] : rem_shift[32:0];
  assign quot_d    = {quot_q[30:0], q_bit};

  assign prod_fix = cond_neg64(acc_q, sign_a_q ^ sign_b_q);
  assign quot_fix = divz_q ? 32'hFFFF_FFFF : cond_neg32(quot_q, sign_a_q ^ sign_b_q);
  assign rem_fix  = cond_neg32(rem_q[31:0], sign_a_q);
  assign res_hi   = is_div_q ? rem_fix  : prod_fix[63:32];
  assign res_lo   = is_div_q ? quot_fix : prod_fix[31:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      hien_q    <= 1'b0;
      loen_q    <= 1'b0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      divz_q    <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_start) begin
            state_q   <= CALC;
            cnt_q     <= '0;
            is_div_q  <= (bus.alucontrol == ALU_DIV);
            hien_q    <= bus.hien;
            loen_q    <= bus.loen;
            sign_a_q  <= bus.srca[31];
            sign_b_q  <= bus.srcb[31];
            divz_q    <= (bus.srcb == 32'd0);
            mcand_q   <= {32'd0, mag32(bus.srca)};
            mplier_q  <= mag32(bus.srcb);
            acc_q     <= '0;
            rem_q     <= '0;
            quot_q    <= mag32(bus.srca);
            divisor_q <= mag32(bus.srcb);
          end
        end
        CALC: begin
          cnt_q    <= cnt_q + 5'd1;
          acc_q    <= acc_d;
          mcand_q  <= {mcand_q[62:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[31:1]};
          rem_q    <= rem_d;
          quot_q   <= quot_d;
          if (cnt_q == MD_ITER_LAST) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          if (hien_q) hi_q <= res_hi;
          if (loen_q) lo_q <= res_lo;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == FIX);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
